// File: rtl/rv32m_pkg.sv
// Shared types and constants for the RV32M multiply issue stage.
//   XLEN        : operand / result width (multiplier product is 2*XLEN)
//   mul_op_t    : funct3 encodings of the multiply ops routed to this block
//   mul_state_t : states of the issue-stage controller
package rv32m_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mul_op_t;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mul_state_t;

endpackage

// File: rtl/rv32m_sign_fix.sv
// Combinational sign correction of the unsigned 2*XLEN product.
//   prod_i   in  2*XLEN  unsigned product of the operand magnitudes
//   neg_i    in  1       true result is negative (operand signs differ)
//   funct3_i in  3       op select; 1xx returns 0
//   result_o out XLEN    low half for MUL, high half for MULH/MULHSU/MULHU
module rv32m_sign_fix
  import rv32m_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2*W-1:0] prod_i,
  input  logic           neg_i,
  input  logic [2:0]     funct3_i,
  output logic [W-1:0]   result_o
);

  logic [2*W-1:0] res64;

  // Two's complement negate; a zero product stays zero with no special case.
  assign res64 = neg_i ? -prod_i : prod_i;

  always_comb begin
    result_o = '0;
    if (!funct3_i[2]) begin
      if (funct3_i == MUL) result_o = res64[W-1:0];
      else                 result_o = res64[2*W-1:W];
    end
  end

endmodule

// File: rtl/rv32m_mul_ctrl.sv
// Issue stage for RV32M multiplies feeding an external unsigned multiplier.
// Latches the request, hands operand magnitudes to the multiplier, waits for
// done, sign-fixes the product and returns it over a valid/ready response.
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_funct3/rs1/rs2       op select and operands
//   flush                    pipeline kill, abandons any in-flight op
//   resp_valid/ready/data    response handshake and rd value
//   mul_start/a/b            one-cycle start and magnitudes to multiplier
//   mul_p/mul_done           product and done from multiplier
module rv32m_mul_ctrl
  import rv32m_pkg::*;
#(
  parameter int W = rv32m_pkg::XLEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2:0]     req_funct3,
  input  logic [W-1:0]   req_rs1,
  input  logic [W-1:0]   req_rs2,
  input  logic           flush,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [W-1:0]   resp_data,
  output logic           mul_start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  input  logic           mul_done
);

  mul_state_t state_q, state_d;
  logic [2:0]   f3_q, f3_d;
  logic         neg_q, neg_d;
  logic [W-1:0] mul_a_q, mul_a_d;
  logic [W-1:0] mul_b_q, mul_b_d;
  logic [W-1:0] resp_data_q, resp_data_d;

  logic         sa, sb;
  logic [W-1:0] fix_res;

  // Operand signs only matter for the signed variants; MUL and 1xx use
  // plain unsigned magnitudes.
  assign sa = req_rs1[W-1] & ((req_funct3 == MULH) | (req_funct3 == MULHSU));
  assign sb = req_rs2[W-1] & (req_funct3 == MULH);

  rv32m_sign_fix #(.W(W)) u_sign_fix (
    .prod_i   (mul_p),
    .neg_i    (neg_q),
    .funct3_i (f3_q),
    .result_o (fix_res)
  );

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    neg_d       = neg_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    resp_data_d = resp_data_q;
    case (state_q)
      // Wait for the multiplier to go idle; covers reset or flush mid-op.
      DRAIN: if (mul_done) state_d = IDLE;
      IDLE: begin
        if (req_valid && !flush) begin
          f3_d    = req_funct3;
          neg_d   = sa ^ sb;
          mul_a_d = sa ? -req_rs1 : req_rs1;
          mul_b_d = sb ? -req_rs2 : req_rs2;
          state_d = ISSUE;
        end
      end
      // mul_done still reads the idle value here, so it is ignored.
      ISSUE: state_d = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (mul_done) begin
          resp_data_d = fix_res;
          state_d     = RESP;
        end
      end
      RESP: if (flush || resp_ready) state_d = IDLE;
      default: state_d = DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DRAIN;
      f3_q        <= '0;
      neg_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      neg_q       <= neg_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mul_start  = (state_q == ISSUE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;

endmodule
